// File: rtl/regfile_wb_scheduler_if.sv
// Write-back scheduler bus: two write-back requesters, decode issue
// port and the register file write port.
interface regfile_wb_scheduler_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_wr;
    logic        issue_stall;
    logic        rf_reg_write;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;

    modport master (
        output req0_valid, req0_rd, req0_data,
        output req1_valid, req1_rd, req1_data,
        output issue_valid, issue_rs1, issue_rs2,
        output issue_rd, issue_wr,
        input  req0_ready, req1_ready, issue_stall,
        input  rf_reg_write, rf_write_reg, rf_write_data
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        input  req1_valid, req1_rd, req1_data,
        input  issue_valid, issue_rs1, issue_rs2,
        input  issue_rd, issue_wr,
        output req0_ready, req1_ready, issue_stall,
        output rf_reg_write, rf_write_reg, rf_write_data
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin write-back scheduler for the 32x32 register file.
// Define RF_WB_SCOREBOARD_EN to add the RAW/WAW issue scoreboard.
module regfile_wb_scheduler (
    input logic                   clk,
    input logic                   reset,
    regfile_wb_scheduler_if.slave bus
);
    logic        rr;
    logic        grant0;
    logic        grant1;
    logic        hs;
    logic [4:0]  g_rd;
    logic [31:0] g_data;
    logic        wr_q;
    logic [4:0]  reg_q;
    logic [31:0] data_q;

    // rr names the requester that wins when both are valid
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || !rr);
        grant1 = bus.req1_valid && (!bus.req0_valid || rr);
        hs     = grant0 || grant1;
        g_rd   = grant1 ? bus.req1_rd : bus.req0_rd;
        g_data = grant1 ? bus.req1_data : bus.req0_data;
    end

    assign bus.req0_ready    = grant0;
    assign bus.req1_ready    = grant1;
    assign bus.rf_reg_write  = wr_q;
    assign bus.rf_write_reg  = reg_q;
    assign bus.rf_write_data = data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr     <= 1'b0;
            wr_q   <= 1'b0;
            reg_q  <= 5'd0;
            data_q <= 32'd0;
        end else begin
            wr_q <= hs && (g_rd != 5'd0);
            if (hs) begin
                reg_q  <= g_rd;
                data_q <= g_data;
                rr     <= grant0;
            end
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] busy;
    logic [31:0] busy_nxt;
    logic        stall;
    logic        accept;

    always_comb begin
        stall = bus.issue_valid
              && (busy[bus.issue_rs1] || busy[bus.issue_rs2]
              || (bus.issue_wr && busy[bus.issue_rd]));
        accept = bus.issue_valid && !stall;
        busy_nxt = busy;
        if (wr_q)
            busy_nxt[reg_q] = 1'b0;
        // set after clear so a forced same-register collision keeps busy
        if (accept && bus.issue_wr && (bus.issue_rd != 5'd0))
            busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign bus.issue_stall = stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= 32'd0;
        else
            busy <= busy_nxt;
    end
`else
    logic unused_issue;
    assign unused_issue = ^{bus.issue_valid, bus.issue_rs1,
                            bus.issue_rs2, bus.issue_rd,
                            bus.issue_wr};
    assign bus.issue_stall = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: vector table,
// hand-written corner sequences and a randomized reference model.
module tb_regfile_wb_scheduler;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    regfile_wb_scheduler_if bus ();

    regfile_wb_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid  = 1'b0;
        bus.req0_rd     = 5'd0;
        bus.req0_data   = 32'd0;
        bus.req1_valid  = 1'b0;
        bus.req1_rd     = 5'd0;
        bus.req1_data   = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_rs1   = 5'd0;
        bus.issue_rs2   = 5'd0;
        bus.issue_rd    = 5'd0;
        bus.issue_wr    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wr);
        bus.issue_valid = 1'b1;
        bus.issue_rs1   = rs1;
        bus.issue_rs2   = rs2;
        bus.issue_rd    = rd;
        bus.issue_wr    = wr;
    endtask

    // randomized-run model state
    bit          hold0, hold1;
    bit          last1;
    bit          busy_m [32];
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic        g0, g1, exp_stall;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();

        vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 1, 5, 32'hDEADBEEF};
        vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF};
        vecs[2] = '{0, 0, 0, 1, 0, 32'h1234, 0, 1, 0, 0, 32'h1234};
        vecs[3] = '{1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1, 1, 32'h11};
        vecs[4] = '{1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 1, 2, 32'h22};
        vecs[5] = '{1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1, 1, 32'h11};
        vecs[6] = '{1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 1, 2, 32'h22};
        vecs[7] = '{0, 0, 0, 1, 31, 32'hFFFFFFFF, 0, 1, 1, 31, 32'hFFFFFFFF};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 32'hFFFFFFFF};

        #12;
        check("reset_we", bus.rf_reg_write, 0);
        check("reset_reg", bus.rf_write_reg, 0);
        check("reset_data", bus.rf_write_data, 0);
        check("reset_r0", bus.req0_ready, 0);
        check("reset_r1", bus.req1_ready, 0);
        check("reset_stall", bus.issue_stall, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.req0_valid = vecs[i].v0;
            bus.req0_rd    = vecs[i].rd0;
            bus.req0_data  = vecs[i].d0;
            bus.req1_valid = vecs[i].v1;
            bus.req1_rd    = vecs[i].rd1;
            bus.req1_data  = vecs[i].d1;
            #1;
            check($sformatf("vec%0d_r0", i), bus.req0_ready, vecs[i].r0);
            check($sformatf("vec%0d_r1", i), bus.req1_ready, vecs[i].r1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_we", i), bus.rf_reg_write, vecs[i].we);
            check($sformatf("vec%0d_reg", i), bus.rf_write_reg, vecs[i].wreg);
            check($sformatf("vec%0d_data", i), bus.rf_write_data, vecs[i].wdata);
        end

`ifdef RF_WB_SCOREBOARD_EN
        // RAW: stall holds through the commit cycle, lifts one cycle later
        do_reset();
        issue(0, 0, 7, 1);
        #1;
        check("raw_first_stall", bus.issue_stall, 0);
        @(negedge clk);
        issue(7, 0, 0, 0);
        #1;
        check("raw_stall", bus.issue_stall, 1);
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd7;
        bus.req0_data  = 32'h77;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        check("raw_stall_n1", bus.issue_stall, 1);
        check("raw_we_n1", bus.rf_reg_write, 1);
        @(negedge clk);
        check("raw_stall_n2", bus.issue_stall, 0);
        // WAW
        issue(0, 0, 3, 1);
        @(negedge clk);
        issue(0, 0, 3, 1);
        #1;
        check("waw_stall", bus.issue_stall, 1);
        bus.issue_wr = 1'b0;
        #1;
        check("waw_nowr_stall", bus.issue_stall, 0);
        bus.issue_valid = 1'b0;
        #1;
        check("novalid_stall", bus.issue_stall, 0);
`endif

        // mid-cycle reset with a pending grant
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd9;
        bus.req0_data  = 32'hA5A5A5A5;
        issue(0, 0, 7, 1);
        @(negedge clk);
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd7;
        bus.req0_data  = 32'h0BADF00D;
        #1;
        check("pre_rst_we", bus.rf_reg_write, 1);
        check("pre_rst_r0", bus.req0_ready, 1);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_we", bus.rf_reg_write, 0);
        check("mid_rst_reg", bus.rf_write_reg, 0);
        check("mid_rst_data", bus.rf_write_data, 0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        check("post_rst_we", bus.rf_reg_write, 0);
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd1;
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd2;
        issue(7, 0, 0, 0);
        #1;
        check("post_rst_rr_r0", bus.req0_ready, 1);
        check("post_rst_rr_r1", bus.req1_ready, 0);
        check("post_rst_stall", bus.issue_stall, 0);

        // randomized run against the model
        do_reset();
        hold0   = 0;
        hold1   = 0;
        last1   = 1;
        exp_we  = 0;
        exp_reg = 0;
        exp_data = 0;
        for (int r = 0; r < 32; r++) busy_m[r] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!hold0) begin
                bus.req0_valid = 1'($urandom_range(0, 1));
                bus.req0_rd    = 5'($urandom_range(0, 7));
                bus.req0_data  = $urandom;
            end
            if (!hold1) begin
                bus.req1_valid = 1'($urandom_range(0, 1));
                bus.req1_rd    = 5'($urandom_range(0, 7));
                bus.req1_data  = $urandom;
            end
            bus.issue_valid = 1'($urandom_range(0, 1));
            bus.issue_rs1   = 5'($urandom_range(0, 7));
            bus.issue_rs2   = 5'($urandom_range(0, 7));
            bus.issue_rd    = 5'($urandom_range(0, 7));
            bus.issue_wr    = 1'($urandom_range(0, 1));
            #1;
            g0 = bus.req0_valid && (!bus.req1_valid || last1);
            g1 = bus.req1_valid && (!bus.req0_valid || !last1);
`ifdef RF_WB_SCOREBOARD_EN
            exp_stall = bus.issue_valid
                && (busy_m[bus.issue_rs1] || busy_m[bus.issue_rs2]
                || (bus.issue_wr && busy_m[bus.issue_rd]));
`else
            exp_stall = 0;
`endif
            check("rnd_r0", bus.req0_ready, g0);
            check("rnd_r1", bus.req1_ready, g1);
            check("rnd_stall", bus.issue_stall, exp_stall);
            @(posedge clk);
            #1;
            if (exp_we) busy_m[exp_reg] = 0;
            if (bus.issue_valid && !exp_stall && bus.issue_wr
                && bus.issue_rd != 0)
                busy_m[bus.issue_rd] = 1;
            if (g0 || g1) begin
                exp_reg  = g1 ? bus.req1_rd : bus.req0_rd;
                exp_data = g1 ? bus.req1_data : bus.req0_data;
                exp_we   = (exp_reg != 0);
                last1    = g1;
            end else begin
                exp_we = 0;
            end
            hold0 = bus.req0_valid && !g0;
            hold1 = bus.req1_valid && !g1;
            check("rnd_we", bus.rf_reg_write, exp_we);
            check("rnd_reg", bus.rf_write_reg, exp_reg);
            check("rnd_data", bus.rf_write_data, exp_data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
